// File: rtl/mtr_duty_gen.sv
// Motor duty generator: turns a signed speed command into a battery-compensated,
// clamped duty target and slews the PWM duty toward it once per 4096-clock period.
module mtr_duty_gen #(
  parameter int                DATA_W    = 12,
  parameter int                COEF_W    = 12,
  parameter logic [DATA_W-1:0] RAMP_STEP = 12'h010,
  parameter logic [DATA_W-1:0] MIN_DUTY  = 12'h030,
  parameter logic [DATA_W-1:0] MAX_DUTY  = 12'hFD0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] spd,
  input  logic                     spd_vld,
  input  logic [COEF_W-1:0]        scale,
  input  logic                     en,
  input  logic                     brake,
  output logic [DATA_W-1:0]        duty,
  output logic                     at_target,
  output logic                     period_end
);

  localparam int                       CNT_W    = 12;
  localparam int                       PROD_W   = DATA_W + COEF_W + 1;
  localparam logic [DATA_W-1:0]        ZERO_SPD = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]         CNT_LAST = '1;
  localparam logic signed [PROD_W-1:0] COMP_MAX = PROD_W'((2 ** (DATA_W-1)) - 1);
  localparam logic signed [PROD_W-1:0] COMP_MIN = -COMP_MAX;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    TRACK = 2'd2,
    BRAKE = 2'd3
  } state_t;

  // scale is Q1.11, so dropping COEF_W-1 fraction bits returns to speed units
  function automatic logic signed [DATA_W-1:0] sat_comp(
    input logic signed [PROD_W-1:0] prod
  );
    logic signed [PROD_W-1:0] shifted;
    shifted = prod >>> (COEF_W - 1);
    if (shifted > COMP_MAX)      shifted = COMP_MAX;
    else if (shifted < COMP_MIN) shifted = COMP_MIN;
    return shifted[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] clamp_tgt(
    input logic signed [DATA_W-1:0] comp
  );
    logic signed [DATA_W+1:0] sum;
    sum = $signed({2'b00, ZERO_SPD}) + $signed({{2{comp[DATA_W-1]}}, comp});
    if (sum < $signed({2'b00, MIN_DUTY}))      sum = $signed({2'b00, MIN_DUTY});
    else if (sum > $signed({2'b00, MAX_DUTY})) sum = $signed({2'b00, MAX_DUTY});
    return sum[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] ramp_step(
    input logic [DATA_W-1:0] cur,
    input logic [DATA_W-1:0] tgt
  );
    logic signed [DATA_W:0] diff;
    logic signed [DATA_W:0] step;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    step = $signed({1'b0, RAMP_STEP});
    if (diff > step)       return cur + RAMP_STEP;
    else if (diff < -step) return cur - RAMP_STEP;
    else                   return tgt;
  endfunction

  logic [CNT_W-1:0]         r_cnt;
  logic signed [PROD_W-1:0] r_prod_p0;
  logic                     r_vld_p0;
  logic signed [DATA_W-1:0] r_comp_p1;
  logic [DATA_W-1:0]        r_duty;
  logic                     r_at_tgt;
  state_t                   r_state;
  state_t                   w_state_nxt;
  logic signed [PROD_W-1:0] w_prod;
  logic [DATA_W-1:0]        w_tgt;
  logic [DATA_W-1:0]        w_tgt_nxt;
  logic [DATA_W-1:0]        w_eff;
  logic [DATA_W-1:0]        w_eff_nxt;
  logic [DATA_W-1:0]        w_duty_nxt;
  logic                     w_bound;

  assign w_prod = $signed({{(COEF_W+1){spd[DATA_W-1]}}, spd})
                * $signed({{(DATA_W+1){1'b0}}, scale});

  // Stage 0: raw speed x gain product
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p0  <= 1'b0;
      r_prod_p0 <= '0;
    end else begin
      r_vld_p0 <= spd_vld;
      if (spd_vld) r_prod_p0 <= w_prod;
    end
  end

  // Stage 1: saturated compensation; the clamped target is a pure function of it
  always_ff @(posedge clk) begin
    if (rst)           r_comp_p1 <= '0;
    else if (r_vld_p0) r_comp_p1 <= sat_comp(r_prod_p0);
  end

  assign w_tgt     = clamp_tgt(r_comp_p1);
  assign w_tgt_nxt = r_vld_p0 ? clamp_tgt(sat_comp(r_prod_p0)) : w_tgt;
  assign w_eff     = en ? w_tgt : ZERO_SPD;
  assign w_eff_nxt = en ? w_tgt_nxt : ZERO_SPD;
  assign w_bound   = (r_cnt == CNT_LAST);

  // The boundary step uses the pre-edge target, so a target landing on this edge waits a period
  always_comb begin
    w_duty_nxt = r_duty;
    if (brake)        w_duty_nxt = ZERO_SPD;
    else if (w_bound) w_duty_nxt = ramp_step(r_duty, w_eff);
  end

  always_comb begin
    w_state_nxt = r_state;
    if (brake) begin
      w_state_nxt = BRAKE;
    end else begin
      case (r_state)
        IDLE: begin
          if (en && (w_eff != r_duty)) w_state_nxt = RAMP;
        end
        RAMP: begin
          if (!en && (r_duty == ZERO_SPD)) w_state_nxt = IDLE;
          else if (r_duty == w_eff)        w_state_nxt = TRACK;
        end
        TRACK: begin
          if (!en && (r_duty == ZERO_SPD)) w_state_nxt = IDLE;
          else if (w_eff != r_duty)        w_state_nxt = RAMP;
        end
        BRAKE:   w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Stage 2: duty, FSM state, at-target flag and period counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_duty   <= ZERO_SPD;
      r_at_tgt <= 1'b1;
      r_state  <= IDLE;
    end else begin
      r_cnt    <= r_cnt + CNT_W'(1);
      r_duty   <= w_duty_nxt;
      r_at_tgt <= (w_duty_nxt == w_eff_nxt);
      r_state  <= w_state_nxt;
    end
  end

  assign duty       = r_duty;
  assign at_target  = r_at_tgt;
  assign period_end = w_bound;

endmodule

// File: tb/tb_mtr_duty_gen.sv
// Directed bench for mtr_duty_gen: reset, ramping, timing at the period
// boundary, saturation/clamping, brake, enable-off and mid-ramp reset.
module tb_mtr_duty_gen;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [11:0] spd;
  logic               spd_vld;
  logic [11:0]        scale;
  logic               en;
  logic               brake;
  logic [11:0]        duty;
  logic               at_target;
  logic               period_end;

  logic [11:0] cnt;
  int          n_chk  = 0;
  int          n_pass = 0;

  logic [11:0] a_spd  [5] = '{12'h7FF, 12'h800, 12'hFFF, 12'h100, 12'hF00};
  logic [11:0] a_scl  [5] = '{12'hFFF, 12'h800, 12'h001, 12'h400, 12'h800};
  logic [11:0] a_comp [5] = '{12'h7FF, 12'h801, 12'hFFF, 12'h080, 12'hF00};
  logic [11:0] a_tgt  [5] = '{12'hFD0, 12'h030, 12'h7FF, 12'h880, 12'h700};

  mtr_duty_gen dut (
    .clk        (clk),
    .rst        (rst),
    .spd        (spd),
    .spd_vld    (spd_vld),
    .scale      (scale),
    .en         (en),
    .brake      (brake),
    .duty       (duty),
    .at_target  (at_target),
    .period_end (period_end)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock; cnt mirrors the period counter the DUT should have
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) cnt = '0;
    else     cnt = cnt + 12'd1;
  endtask

  task automatic go_to(input logic [11:0] v);
    while (cnt != v) tick();
  endtask

  task automatic cmd(input logic [11:0] s, input logic [11:0] sc);
    spd     = s;
    scale   = sc;
    spd_vld = 1'b1;
    tick();
    spd_vld = 1'b0;
  endtask

  task automatic boundary();
    go_to(12'hFFF);
    tick();
  endtask

  initial begin
    rst = 1'b1; spd_vld = 1'b0; en = 1'b0; brake = 1'b0;
    spd = '0; scale = 12'h800; cnt = '0;
    tick();
    tick();
    chk("rst_duty", duty, 12'h800);
    chk("rst_at", at_target, 1);
    chk("rst_pe", period_end, 0);
    chk("rst_cnt", dut.r_cnt, 0);
    rst = 1'b0;

    go_to(12'hFFE);
    chk("pe_early", period_end, 0);
    tick();
    chk("pe_first", period_end, 1);
    tick();
    chk("pe_clear", period_end, 0);
    chk("idle_duty", duty, 12'h800);

    // Unity gain, +0x40 -> target 0x840, four ramp steps
    en = 1'b1;
    go_to(12'd16);
    cmd(12'h040, 12'h800);
    chk("lat1_at", at_target, 1);
    tick();
    chk("lat2_at", at_target, 0);
    go_to(12'hFFF);
    chk("hold_mid", duty, 12'h800);
    tick();
    chk("ramp1", duty, 12'h810);
    for (int k = 2; k <= 4; k++) begin
      boundary();
      chk("ramp_k", duty, 12'h800 + 12'(16 * k));
      chk("ramp_at", at_target, (k == 4) ? 1 : 0);
    end

    // Final step smaller than RAMP_STEP must land exactly
    go_to(12'd100);
    cmd(12'h048, 12'h800);
    tick();
    chk("small_at0", at_target, 0);
    boundary();
    chk("small_step", duty, 12'h848);
    chk("small_at1", at_target, 1);

    // Command two clocks before the boundary is applied at it
    go_to(12'hFFD);
    cmd(12'h060, 12'h800);
    tick();
    chk("late2_hold", duty, 12'h848);
    tick();
    chk("late2_apply", duty, 12'h858);
    // One clock before: boundary still uses the old 0x860 target
    go_to(12'hFFE);
    cmd(12'h020, 12'h800);
    tick();
    chk("late1_old", duty, 12'h860);
    // Back-to-back commands: the last one (0x900) wins
    go_to(12'd100);
    spd = 12'h010; scale = 12'h800; spd_vld = 1'b1;
    tick();
    spd = 12'h100;
    tick();
    spd_vld = 1'b0;
    boundary();
    chk("b2b_last", duty, 12'h870);

    // Saturation, clamping and arithmetic shift
    for (int i = 0; i < 5; i++) begin
      cmd(a_spd[i], a_scl[i]);
      tick();
      chk("comp", {20'd0, dut.r_comp_p1}, a_comp[i]);
      chk("tgt", {20'd0, dut.w_tgt}, a_tgt[i]);
    end

    // Brake mid-ramp at 0x880
    cmd(12'h100, 12'h800);
    boundary();
    chk("pre_brk", duty, 12'h880);
    go_to(12'd50);
    brake = 1'b1;
    tick();
    chk("brk_duty", duty, 12'h800);
    chk("brk_state", {30'd0, dut.r_state}, 3);
    chk("brk_at", at_target, 0);
    cmd(12'h020, 12'h800);
    tick();
    chk("brk_capture", {20'd0, dut.w_tgt}, 12'h820);
    chk("brk_hold", duty, 12'h800);
    brake = 1'b0;
    tick();
    chk("rel_state", {30'd0, dut.r_state}, 0);
    boundary();
    chk("rel_ramp1", duty, 12'h810);
    boundary();
    chk("rel_ramp2", duty, 12'h820);
    chk("rel_at", at_target, 1);

    // Enable off: ramp back to zero speed
    en = 1'b0;
    tick();
    chk("dis_at0", at_target, 0);
    boundary();
    chk("dis_ramp1", duty, 12'h810);
    boundary();
    chk("dis_ramp2", duty, 12'h800);
    chk("dis_at1", at_target, 1);
    tick();
    tick();
    chk("dis_state", {30'd0, dut.r_state}, 0);
    cmd(12'h100, 12'h800);
    tick();
    chk("dis_tgt_upd", {20'd0, dut.w_tgt}, 12'h900);
    chk("dis_at_keep", at_target, 1);

    // Reset overrides brake/spd_vld and discards the pending target
    en = 1'b1; brake = 1'b1; spd = 12'h7FF; spd_vld = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; brake = 1'b0; spd_vld = 1'b0;
    chk("rst2_duty", duty, 12'h800);
    chk("rst2_at", at_target, 1);
    chk("rst2_pe", period_end, 0);
    chk("rst2_cnt", dut.r_cnt, 0);
    chk("rst2_tgt", {20'd0, dut.w_tgt}, 12'h800);
    go_to(12'hFFF);
    chk("rst2_pe1", period_end, 1);
    tick();
    chk("rst2_stay", duty, 12'h800);
    chk("rst2_at1", at_target, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
